serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_sub_pkg.sv | 16 +
 rtl/full_subtractor.sv | 14 +
 rtl/serial_subtractor.sv | 113 +++++++++++
 tb/tb_serial_subtractor.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
// Holds the FSM state encoding and the bit-counter width helper.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit counter must index 0..N-1, so clog2(N) bits (at least 1).
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: d = x - y - bin, combinational (zero latency).
// No flow control; purely combinational.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// LSB-first serial subtractor, N cycles in RUN then a one-cycle done pulse; start ignored while busy.
// Define SERIAL_SUB_SAT_EN to clamp diff to 0 whenever the final borrow is set.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         borrow
);

  localparam int CNT_W = cnt_width(N);

  state_t           state;
  state_t           state_nxt;
  logic [N-1:0]     a_sr;
  logic [N-1:0]     b_sr;
  logic [CNT_W-1:0] cnt;
  logic             brw;
  logic             bit_d;
  logic             bit_bout;
  logic             last_bit;
  logic             accept;
  logic [N-1:0]     result;

  full_subtractor u_fs (
    .x    (a_sr[0]),
    .y    (b_sr[0]),
    .bin  (brw),
    .d    (bit_d),
    .bout (bit_bout)
  );

  assign last_bit = (cnt == CNT_W'(N - 1));
  // Result bits shift into the top of the minuend register as its bits shift out.
  assign result   = {bit_d, a_sr[N-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      cnt    <= '0;
      brw    <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
    end else if (accept) begin
      a_sr <= a;
      b_sr <= b;
      cnt  <= '0;
      brw  <= 1'b0;
    end else if (state == RUN) begin
      a_sr <= result;
      b_sr <= {1'b0, b_sr[N-1:1]};
      brw  <= bit_bout;
      cnt  <= cnt + CNT_W'(1);
      if (last_bit) begin
        borrow <= bit_bout;
`ifdef SERIAL_SUB_SAT_EN
        diff   <= bit_bout ? '0 : result;
`else
        diff   <= result;
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: N=32 and N=8 instances against a cycle-level arithmetic model.
module tb_serial_subtractor;

  localparam int NW = 32;
  localparam int NN = 8;
`ifdef SERIAL_SUB_SAT_EN
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i [2];
  logic [31:0] a_i     [2];
  logic [31:0] b_i     [2];
  logic        busy_o  [2];
  logic        done_o  [2];
  logic        borrow_o[2];
  logic [31:0] diff_o  [2];

  logic        busy32, done32, borrow32, busy8, done8, borrow8;
  logic [31:0] diff32;
  logic [7:0]  diff8;

  int n_checks = 0;
  int n_fail   = 0;
  int ndone[2];

  always #5 clk = ~clk;

  serial_subtractor #(.N(NW)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start_i[0]), .a(a_i[0]), .b(b_i[0]),
    .busy(busy32), .done(done32), .diff(diff32), .borrow(borrow32)
  );

  serial_subtractor #(.N(NN)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start_i[1]), .a(a_i[1][7:0]), .b(b_i[1][7:0]),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
  );

  assign busy_o[0] = busy32;  assign done_o[0] = done32;
  assign diff_o[0] = diff32;  assign borrow_o[0] = borrow32;
  assign busy_o[1] = busy8;   assign done_o[1] = done8;
  assign diff_o[1] = {24'h0, diff8}; assign borrow_o[1] = borrow8;

  function automatic int wid(input int u);
    return (u == 0) ? NW : NN;
  endfunction

  function automatic logic [31:0] mask(input int u);
    return (u == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
  endfunction

  function automatic logic [31:0] ref_diff(input int u, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    d = (a - b) & mask(u);
    if (SAT && ((a & mask(u)) < (b & mask(u)))) d = 32'h0;
    return d;
  endfunction

  function automatic logic ref_borrow(input int u, input logic [31:0] a, input logic [31:0] b);
    return (a & mask(u)) < (b & mask(u));
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 3))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return $urandom_range(0, 3);
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an accepted operation publishes its arithmetic result exactly N edges later.
  logic        m_busy[2], m_done[2], m_borrow[2], p_borrow[2];
  logic [31:0] m_diff[2], p_diff[2];
  int          m_left[2];

  always @(posedge clk or negedge rst_n) begin
    for (int u = 0; u < 2; u++) begin
      if (!rst_n) begin
        m_busy[u] <= 1'b0; m_done[u] <= 1'b0; m_borrow[u] <= 1'b0;
        m_diff[u] <= 32'h0; m_left[u] <= 0;
        p_diff[u] <= 32'h0; p_borrow[u] <= 1'b0;
      end else begin
        m_done[u] <= 1'b0;
        if (m_busy[u]) begin
          m_left[u] <= m_left[u] - 1;
          if (m_left[u] == 1) begin
            m_busy[u]   <= 1'b0;
            m_done[u]   <= 1'b1;
            m_diff[u]   <= p_diff[u];
            m_borrow[u] <= p_borrow[u];
          end
        end else if (start_i[u]) begin
          m_busy[u]   <= 1'b1;
          m_left[u]   <= wid(u);
          p_diff[u]   <= ref_diff(u, a_i[u], b_i[u]);
          p_borrow[u] <= ref_borrow(u, a_i[u], b_i[u]);
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("u%0d busy", u),   {63'h0, busy_o[u]},   {63'h0, m_busy[u]});
      chk($sformatf("u%0d done", u),   {63'h0, done_o[u]},   {63'h0, m_done[u]});
      chk($sformatf("u%0d diff", u),   {32'h0, diff_o[u]},   {32'h0, m_diff[u]});
      chk($sformatf("u%0d borrow", u), {63'h0, borrow_o[u]}, {63'h0, m_borrow[u]});
      if (m_done[u]) ndone[u]++;
    end
  end

  task automatic run_op(input int u, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ed, input logic eb, input string name);
    int cyc;
    @(negedge clk);
    start_i[u] = 1'b1; a_i[u] = a; b_i[u] = b;
    @(negedge clk);
    start_i[u] = 1'b0; a_i[u] = $urandom; b_i[u] = $urandom;
    cyc = 1;
    while (!done_o[u] && cyc < wid(u) + 10) begin
      @(negedge clk);
      cyc++;
      a_i[u] = $urandom; b_i[u] = $urandom;
    end
    chk({name, " latency"}, cyc, wid(u) + 1);
    chk({name, " diff"}, {32'h0, diff_o[u]}, {32'h0, ed});
    chk({name, " borrow"}, {63'h0, borrow_o[u]}, {63'h0, eb});
  endtask

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    int t1, t2, cnt;
    logic [31:0] d1, d2, corner[6];
    logic        bw1, bw2;
    corner = '{32'h00, 32'h01, 32'h7F, 32'h80, 32'hFE, 32'hFF};
    ndone = '{0, 0};
    for (int u = 0; u < 2; u++) begin
      start_i[u] = 1'b0; a_i[u] = 32'h0; b_i[u] = 32'h0;
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset busy",   {63'h0, busy_o[0]},   64'h0);
    chk("reset done",   {63'h0, done_o[0]},   64'h0);
    chk("reset diff",   {32'h0, diff_o[0]},   64'h0);
    chk("reset borrow", {63'h0, borrow_o[0]}, 64'h0);
    #2 rst_n = 1'b1;

    run_op(0, 32'd7, 32'd5, 32'd2, 1'b0, "7-5");
    run_op(0, 32'd5, 32'd7, SAT ? 32'h0 : 32'hFFFF_FFFE, 1'b1, "5-7");
    run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, "max-max");
    run_op(0, 32'd0, 32'd1, SAT ? 32'h0 : 32'hFFFF_FFFF, 1'b1, "0-1");
    run_op(0, 32'd0, 32'd0, 32'h0, 1'b0, "0-0");
    run_op(0, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 1'b0, "max-0");
    run_op(0, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, "msb-1");

    // Back-to-back with start held high; operands scrambled during RUN.
    t1 = -1; t2 = -1; d1 = 0; d2 = 0; bw1 = 0; bw2 = 0;
    @(negedge clk);
    start_i[0] = 1'b1; a_i[0] = 32'd10; b_i[0] = 32'd3;
    for (int j = 1; j <= 2 * NW + 6; j++) begin
      @(negedge clk);
      if (done_o[0]) begin
        if (t1 < 0) begin t1 = j; d1 = diff_o[0]; bw1 = borrow_o[0]; end
        else if (t2 < 0) begin t2 = j; d2 = diff_o[0]; bw2 = borrow_o[0]; end
      end
      start_i[0] = (j <= NW + 1);
      if (j == NW || j == NW + 1) begin
        a_i[0] = 32'd3; b_i[0] = 32'd10;
      end else begin
        a_i[0] = $urandom; b_i[0] = $urandom;
      end
    end
    chk("b2b first done cycle", t1, NW + 1);
    chk("b2b done spacing", t2 - t1, NW + 1);
    chk("b2b first diff", {32'h0, d1}, 64'd7);
    chk("b2b first borrow", {63'h0, bw1}, 64'h0);
    chk("b2b second diff", {32'h0, d2}, SAT ? 64'h0 : 64'hFFFF_FFF9);
    chk("b2b second borrow", {63'h0, bw2}, 64'h1);

    // Reset in the middle of a run.
    @(negedge clk);
    start_i[0] = 1'b1; a_i[0] = 32'd123; b_i[0] = 32'd45;
    @(negedge clk);
    start_i[0] = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst busy",   {63'h0, busy_o[0]},   64'h0);
    chk("async rst done",   {63'h0, done_o[0]},   64'h0);
    chk("async rst diff",   {32'h0, diff_o[0]},   64'h0);
    chk("async rst borrow", {63'h0, borrow_o[0]}, 64'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    cnt = 0;
    repeat (NW + 8) begin
      @(negedge clk);
      if (done_o[0]) cnt++;
    end
    chk("no done after abort", cnt, 0);
    run_op(0, 32'd100, 32'd1, 32'd99, 1'b0, "100-1");

    // N=8 corner operand pairs.
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++)
        run_op(1, corner[i], corner[j], ref_diff(1, corner[i], corner[j]),
               ref_borrow(1, corner[i], corner[j]), $sformatf("n8 %0h-%0h", corner[i], corner[j]));

    // Random traffic on both instances; the per-cycle compare does the checking.
    ndone = '{0, 0};
    repeat (15000) begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        start_i[u] = ($urandom_range(0, 3) != 0);
        a_i[u] = pick();
        b_i[u] = pick();
      end
    end
    @(negedge clk);
    start_i[0] = 1'b0; start_i[1] = 1'b0;
    repeat (NW + 4) @(negedge clk);
    chk("n32 random activity", {63'h0, ndone[0] > 100}, 64'h1);
    chk("n8 random activity",  {63'h0, ndone[1] > 500}, 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
